efpga_axil_reg_slave: RTL and testbench

//  AXI4-Lite responder (slave) exposing NUM_REGS 32-bit read/write registers to the PS-side master.

---
 rtl/efpga_axil_pkg.sv | 42 ++++
 rtl/efpga_axil_reg_slave_if.sv | 37 +++
 rtl/efpga_axil_wr_join.sv | 113 +++++++++++
 rtl/efpga_axil_reg_slave.sv | 168 ++++++++++++++++
 tb/tb_efpga_axil_reg_slave.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/efpga_axil_pkg.sv
// rtl/efpga_axil_pkg.sv - shared types and byte-strobe helper for the AXI4-Lite register slave
package efpga_axil_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    // Merge new write data into an existing word, byte lane by byte lane.
    function automatic logic [AXIL_DATA_W-1:0] apply_wstrb(
        input logic [AXIL_DATA_W-1:0] old,
        input logic [AXIL_DATA_W-1:0] wdata,
        input logic [AXIL_STRB_W-1:0] wstrb
    );
        logic [AXIL_DATA_W-1:0] res;
        res = old;
        for (int j = 0; j < AXIL_STRB_W; j++) begin
            if (wstrb[j]) begin
                res[j*8 +: 8] = wdata[j*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/efpga_axil_reg_slave_if.sv
// rtl/efpga_axil_reg_slave_if.sv - AXI4-Lite bus bundle with master and slave views
interface efpga_axil_reg_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/efpga_axil_wr_join.sv
// rtl/efpga_axil_wr_join.sv - joins AW and W handshakes into a single write-commit pulse
module efpga_axil_wr_join
    import efpga_axil_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IDX_W-1:0]       aw_idx,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [AXIL_DATA_W-1:0] wdata,
    input  logic [AXIL_STRB_W-1:0] wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic                   resp_done,
    output logic                   commit,
    output logic [IDX_W-1:0]       commit_idx,
    output logic [AXIL_DATA_W-1:0] commit_data,
    output logic [AXIL_STRB_W-1:0] commit_strb
);

    wr_state_t              state_q, state_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [AXIL_DATA_W-1:0] data_q, data_d;
    logic [AXIL_STRB_W-1:0] strb_q, strb_d;
    logic                   aw_hs, w_hs;

    assign aw_hs   = awvalid && awready_q;
    assign w_hs    = wvalid && wready_q;
    assign awready = awready_q;
    assign wready  = wready_q;

    // Next state: latch whichever half arrives first, commit when both are present.
    always_comb begin
        state_d     = state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        idx_d       = idx_q;
        data_d      = data_q;
        strb_d      = strb_q;
        commit      = 1'b0;
        commit_idx  = aw_idx;
        commit_data = wdata;
        commit_strb = wstrb;
        case (state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit    = 1'b1;
                    state_d   = WR_RESP;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end else if (aw_hs) begin
                    idx_d     = aw_idx;
                    state_d   = WR_WAIT_W;
                    awready_d = 1'b0;
                end else if (w_hs) begin
                    data_d   = wdata;
                    strb_d   = wstrb;
                    state_d  = WR_WAIT_AW;
                    wready_d = 1'b0;
                end
            end
            WR_WAIT_W: begin
                commit_idx = idx_q;
                if (w_hs) begin
                    commit   = 1'b1;
                    state_d  = WR_RESP;
                    wready_d = 1'b0;
                end
            end
            WR_WAIT_AW: begin
                commit_data = data_q;
                commit_strb = strb_q;
                if (aw_hs) begin
                    commit    = 1'b1;
                    state_d   = WR_RESP;
                    awready_d = 1'b0;
                end
            end
            WR_RESP: begin
                if (resp_done) begin
                    state_d   = WR_IDLE;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    // State and registered readies; both readies come out of reset high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WR_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            idx_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

endmodule

// File: rtl/efpga_axil_reg_slave.sv
// rtl/efpga_axil_reg_slave.sv - AXI4-Lite register slave top; EFPGA_AXIL_SLVERR_EN makes out-of-range accesses answer SLVERR
module efpga_axil_reg_slave
    import efpga_axil_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = AXIL_DATA_W
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    efpga_axil_reg_slave_if.slave      s_axi,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_wr_pulse
);

    localparam int IDX_W = ADDR_W - 2;

`ifdef EFPGA_AXIL_SLVERR_EN
    localparam axi_resp_t OOR_RESP = SLVERR;
`else
    localparam axi_resp_t OOR_RESP = OKAY;
`endif

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic                bvalid_q, bvalid_d;
    axi_resp_t           bresp_q, bresp_d;
    rd_state_t           rd_state_q, rd_state_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    axi_resp_t           rresp_q, rresp_d;
    logic [DATA_W-1:0]   rd_word;

    logic                commit;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;
    logic                wr_in_range;
    logic [IDX_W-1:0]    rd_idx;
    logic                rd_in_range;
    logic                unused_bits;

    // Protection bits and sub-word address bits carry no meaning here.
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    efpga_axil_wr_join #(
        .IDX_W (IDX_W)
    ) u_wr_join (
        .clk         (ACLK),
        .rst         (ARESET),
        .aw_idx      (s_axi.awaddr[ADDR_W-1:2]),
        .awvalid     (s_axi.awvalid),
        .awready     (s_axi.awready),
        .wdata       (s_axi.wdata),
        .wstrb       (s_axi.wstrb),
        .wvalid      (s_axi.wvalid),
        .wready      (s_axi.wready),
        .resp_done   (bvalid_q && s_axi.bready),
        .commit      (commit),
        .commit_idx  (wr_idx),
        .commit_data (wr_data),
        .commit_strb (wr_strb)
    );

    assign wr_in_range = 32'(wr_idx) < NUM_REGS;
    assign rd_idx      = s_axi.araddr[ADDR_W-1:2];
    assign rd_in_range = 32'(rd_idx) < NUM_REGS;

    // Register update, write pulse and B channel; out-of-range commits only produce a response.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && wr_idx == IDX_W'(i)) begin
                regs_d[i]     = apply_wstrb(regs_q[i], wr_data, wr_strb);
                wr_pulse_d[i] = 1'b1;
            end
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_in_range ? OKAY : OOR_RESP;
        end else if (bvalid_q && s_axi.bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read FSM; rdata is taken from the pre-commit register contents.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_word    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_word = regs_q[i];
            end
        end
        case (rd_state_q)
            RD_IDLE: begin
                if (s_axi.arvalid && arready_q) begin
                    rdata_d    = rd_word;
                    rresp_d    = rd_in_range ? OKAY : OOR_RESP;
                    rvalid_d   = 1'b1;
                    arready_d  = 1'b0;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (s_axi.rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // All slave-side state; reset drops any in-flight response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Flatten the register array for the fabric.
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign reg_wr_pulse  = wr_pulse_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_efpga_axil_reg_slave.sv
// tb/tb_efpga_axil_reg_slave.sv - bench driving a 4-register and a 3-register slave with identical traffic
module tb_efpga_axil_reg_slave;

`ifdef EFPGA_AXIL_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif
    localparam logic [1:0] OK = 2'b00;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        int          dly;
        logic [31:0] exp_d4;
        logic [31:0] exp_d3;
        logic [1:0]  exp_r3;
    } vec_t;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    logic [3:0]  awaddr, araddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;

    efpga_axil_reg_slave_if #(.ADDR_W(4), .DATA_W(32)) a4 ();
    efpga_axil_reg_slave_if #(.ADDR_W(4), .DATA_W(32)) a3 ();

    assign a4.awaddr = awaddr;  assign a3.awaddr = awaddr;
    assign a4.awprot = 3'b010;  assign a3.awprot = 3'b010;
    assign a4.awvalid = awvalid; assign a3.awvalid = awvalid;
    assign a4.wdata = wdata;    assign a3.wdata = wdata;
    assign a4.wstrb = wstrb;    assign a3.wstrb = wstrb;
    assign a4.wvalid = wvalid;  assign a3.wvalid = wvalid;
    assign a4.bready = bready;  assign a3.bready = bready;
    assign a4.araddr = araddr;  assign a3.araddr = araddr;
    assign a4.arprot = 3'b001;  assign a3.arprot = 3'b001;
    assign a4.arvalid = arvalid; assign a3.arvalid = arvalid;
    assign a4.rready = rready;  assign a3.rready = rready;

    logic [127:0] reg_q4;
    logic [95:0]  reg_q3;
    logic [3:0]   pulse4;
    logic [2:0]   pulse3;

    efpga_axil_reg_slave #(.ADDR_W(4), .NUM_REGS(4), .DATA_W(32)) u_dut4 (
        .ACLK(clk), .ARESET(areset), .s_axi(a4.slave), .reg_q(reg_q4), .reg_wr_pulse(pulse4)
    );
    efpga_axil_reg_slave #(.ADDR_W(4), .NUM_REGS(3), .DATA_W(32)) u_dut3 (
        .ACLK(clk), .ARESET(areset), .s_axi(a3.slave), .reg_q(reg_q3), .reg_wr_pulse(pulse3)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] m4 [4];
    logic [31:0] m3 [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        for (int j = 0; j < 4; j++) begin
            if (strb[j]) begin
                m4[idx][8*j +: 8] = data[8*j +: 8];
                if (idx < 3) m3[idx][8*j +: 8] = data[8*j +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m4[i] = '0;
            m3[i] = '0;
        end
    endtask

    task automatic chk_regs();
        logic [127:0] e4;
        logic [95:0]  e3;
        for (int i = 0; i < 4; i++) e4[i*32 +: 32] = m4[i];
        for (int i = 0; i < 3; i++) e3[i*32 +: 32] = m3[i];
        chk("reg_q4", reg_q4, e4);
        chk("reg_q3", {32'h0, reg_q3}, {32'h0, e3});
    endtask

    // lead > 0: W raised lead cycles before AW; lead < 0: AW first.
    task automatic write_txn(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int bdelay, input logic [1:0] exp_b4, input logic [1:0] exp_b3);
        bit aw_pend, w_pend, aw_hs, w_hs;
        int cyc, idx;
        idx = int'(addr) / 4;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        aw_pend = 1'b1; w_pend = 1'b1;
        wvalid = (lead >= 0);
        awvalid = (lead <= 0);
        cyc = 0;
        while ((aw_pend || w_pend) && cyc < 20) begin
            aw_hs = awvalid && a4.awready;
            w_hs = wvalid && a4.wready;
            @(negedge clk);
            cyc++;
            if (aw_hs) begin awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_hs) begin wvalid = 1'b0; w_pend = 1'b0; end
            if (aw_pend && !awvalid && cyc >= lead) awvalid = 1'b1;
            if (w_pend && !wvalid && cyc >= -lead) wvalid = 1'b1;
            if (aw_pend || w_pend) chk("bvalid_early", a4.bvalid, 1'b0);
            if (!w_pend && aw_pend) chk("wready_wait_aw", {a4.wready, a3.wready}, 2'b00);
            if (!aw_pend && w_pend) chk("awready_wait_w", {a4.awready, a3.awready}, 2'b00);
        end
        chk("wr_hs_timeout", aw_pend || w_pend, 1'b0);
        chk("bvalid", {a4.bvalid, a3.bvalid}, 2'b11);
        chk("bresp4", a4.bresp, exp_b4);
        chk("bresp3", a3.bresp, exp_b3);
        chk("pulse4", pulse4, 4'b0001 << idx);
        chk("pulse3", pulse3, (idx < 3) ? (3'b001 << idx) : 3'b000);
        model_write(addr, data, strb);
        chk_regs();
        for (int k = 0; k < bdelay; k++) begin
            @(negedge clk);
            chk("bvalid_hold", {a4.bvalid, a3.bvalid}, 2'b11);
            chk("bresp_hold", {a4.bresp, a3.bresp}, {exp_b4, exp_b3});
            chk("awready_in_resp", {a4.awready, a4.wready}, 2'b00);
            chk("pulse_once", {pulse4, pulse3}, 7'b0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("b_done", {a4.bvalid, a3.bvalid}, 2'b00);
        chk("readies_after_b", {a4.awready, a4.wready}, 2'b11);
        chk("pulse_cleared", {pulse4, pulse3}, 7'b0);
    endtask

    task automatic read_txn(input logic [3:0] addr, input int dly, input logic [31:0] exp_d4,
                            input logic [31:0] exp_d3, input logic [1:0] exp_r4, input logic [1:0] exp_r3);
        @(negedge clk);
        araddr = addr;
        arvalid = 1'b1;
        chk("arready_idle", {a4.arready, a3.arready}, 2'b11);
        @(negedge clk);
        arvalid = 1'b0;
        for (int k = 0; k <= dly; k++) begin
            chk("rvalid", {a4.rvalid, a3.rvalid}, 2'b11);
            chk("rdata4", a4.rdata, exp_d4);
            chk("rdata3", a3.rdata, exp_d3);
            chk("rresp", {a4.rresp, a3.rresp}, {exp_r4, exp_r3});
            chk("arready_in_resp", a4.arready, 1'b0);
            if (k < dly) @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("r_done", {a4.rvalid, a3.rvalid, a4.arready}, 3'b001);
    endtask

    function automatic vec_t wr_v(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                                  input int lead, input int dly, input logic [1:0] r3);
        vec_t v;
        v.wr = 1'b1; v.addr = a; v.data = d; v.strb = s; v.lead = lead; v.dly = dly;
        v.exp_d4 = '0; v.exp_d3 = '0; v.exp_r3 = r3;
        return v;
    endfunction

    function automatic vec_t rd_v(input logic [3:0] a, input int dly, input logic [31:0] d4,
                                  input logic [31:0] d3, input logic [1:0] r3);
        vec_t v;
        v.wr = 1'b0; v.addr = a; v.data = '0; v.strb = '0; v.lead = 0; v.dly = dly;
        v.exp_d4 = d4; v.exp_d3 = d3; v.exp_r3 = r3;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        logic [31:0] old4, old3, d, e3;
        logic [3:0]  a;
        int          idx;

        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        areset = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);

        chk("rst_readies", {a4.awready, a4.wready, a4.arready, a3.awready, a3.wready, a3.arready}, 6'h3f);
        chk("rst_valids", {a4.bvalid, a4.rvalid, a3.bvalid, a3.rvalid}, 4'h0);
        chk("rst_resps", {a4.bresp, a4.rresp, a3.bresp, a3.rresp}, 8'h00);
        chk("rst_rdata", {a4.rdata, a3.rdata}, 64'h0);
        chk("rst_pulse", {pulse4, pulse3}, 7'b0);
        chk_regs();

        vecs.push_back(wr_v(4'h0, 32'h1, 4'hf, 0, 0, OK));
        vecs.push_back(wr_v(4'h4, 32'h2, 4'hf, -2, 0, OK));
        vecs.push_back(wr_v(4'h8, 32'h3, 4'hf, 3, 0, OK));
        vecs.push_back(wr_v(4'hC, 32'h4, 4'hf, 0, 0, ERR));
        vecs.push_back(rd_v(4'h0, 0, 32'h1, 32'h1, OK));
        vecs.push_back(rd_v(4'h4, 1, 32'h2, 32'h2, OK));
        vecs.push_back(rd_v(4'h8, 0, 32'h3, 32'h3, OK));
        vecs.push_back(rd_v(4'hC, 2, 32'h4, 32'h0, ERR));
        vecs.push_back(wr_v(4'h0, 32'h11223344, 4'hf, 0, 5, OK));
        vecs.push_back(wr_v(4'h0, 32'hAABBCCDD, 4'b0101, 1, 0, OK));
        vecs.push_back(rd_v(4'h0, 0, 32'h11BB33DD, 32'h11BB33DD, OK));
        vecs.push_back(wr_v(4'hE, 32'hDEADBEEF, 4'hf, -1, 0, ERR));
        vecs.push_back(rd_v(4'hF, 0, 32'hDEADBEEF, 32'h0, ERR));
        vecs.push_back(rd_v(4'h9, 0, 32'h3, 32'h3, OK));

        foreach (vecs[i]) begin
            if (vecs[i].wr)
                write_txn(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, vecs[i].dly, OK, vecs[i].exp_r3);
            else
                read_txn(vecs[i].addr, vecs[i].dly, vecs[i].exp_d4, vecs[i].exp_d3, OK, vecs[i].exp_r3);
        end

        // Read and write commit hit register 1 on the same edge: read sees the old value.
        @(negedge clk);
        old4 = m4[1]; old3 = m3[1]; d = $urandom;
        awaddr = 4'h4; wdata = d; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h4; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rw_same_rdata4", a4.rdata, old4);
        chk("rw_same_rdata3", a3.rdata, old3);
        chk("rw_same_valids", {a4.bvalid, a4.rvalid}, 2'b11);
        model_write(4'h4, d, 4'hf);
        chk_regs();
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        chk("rw_same_done", {a4.bvalid, a4.rvalid, a3.bvalid, a3.rvalid}, 4'h0);

        // Reset while both responses are pending.
        @(negedge clk);
        awaddr = 4'h8; wdata = $urandom; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h0; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("pre_rst_valids", {a4.bvalid, a4.rvalid}, 2'b11);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        model_clear();
        chk("midrst_valids", {a4.bvalid, a4.rvalid, a3.bvalid, a3.rvalid}, 4'h0);
        chk("midrst_pulse", {pulse4, pulse3}, 7'b0);
        chk_regs();
        @(negedge clk);
        chk("midrst_readies", {a4.awready, a4.wready, a4.arready}, 3'b111);

        // Random traffic against the byte-lane model.
        for (int n = 0; n < 40; n++) begin
            a = 4'($urandom_range(0, 15));
            idx = int'(a) / 4;
            if ($urandom_range(0, 1) == 1) begin
                write_txn(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                          int'($urandom_range(0, 3)), OK, (idx < 3) ? OK : ERR);
            end else begin
                e3 = (idx < 3) ? m3[idx] : 32'h0;
                read_txn(a, int'($urandom_range(0, 3)), m4[idx], e3, OK, (idx < 3) ? OK : ERR);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
